// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI serf and its input conditioning.
package spi_pkg;

    localparam int SPI_WIDTH = 16;
    localparam int SPI_CNT_W = 5;

    // Bit count at which a full word has been clocked in.
    localparam logic [SPI_CNT_W-1:0] SPI_CNT_FULL = SPI_CNT_W'(SPI_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PORCH = 2'd1,
        XFER  = 2'd2
    } serf_state_t;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a one-flop
// edge detector; reports the synced level and single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples its predecessor's pre-edge value; blocking would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule : spi_sync_edge

// File: rtl/spi_serf.sv
// spi_serf: 16-bit CPOL=1/CPHA=1 SPI target. Shifts a word in on MOSI while
// returning a preloaded word on MISO, and flags each completed word on rdy.
module spi_serf
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 SCLK,
    input  logic                 MOSI,
    output tri                   MISO,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_ld,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rdy,
    input  logic                 clr_rdy
);

    logic ss_lvl_unused, ss_rise, ss_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_synced;

    serf_state_t            state_q,     state_d;
    logic [SPI_WIDTH-1:0]   shft_q,      shft_d;
    logic [SPI_CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic                   mosi_smpl_q, mosi_smpl_d;
    logic [SPI_WIDTH-1:0]   rx_data_q,   rx_data_d;
    logic                   rdy_q,       rdy_d;
    logic [SPI_WIDTH-1:0]   shift_in;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_ss_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (SS_n),
        .level_o (ss_lvl_unused),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (SCLK),
        .level_o (sclk_lvl_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // MOSI gets the same synchronizer depth as SCLK so the sample lines up with sclk_rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign mosi_synced = mosi_sync_q[SYNC_STAGES-1];
    assign shift_in    = {shft_q[SPI_WIDTH-2:0], mosi_smpl_q};

    // NOTE: every next-state signal is given its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        shft_d      = shft_q;
        bit_cnt_d   = bit_cnt_q;
        mosi_smpl_d = mosi_smpl_q;
        rx_data_d   = rx_data_q;
        rdy_d       = rdy_q;

        if (clr_rdy) begin
            rdy_d = 1'b0;
        end

        if (sclk_rise && (state_q != IDLE)) begin
            mosi_smpl_d = mosi_synced;
        end

        case (state_q)
            IDLE: begin
                if (tx_ld || ss_fall) begin
                    shft_d = tx_data;
                end
                if (ss_fall) begin
                    bit_cnt_d = '0;
                    state_d   = PORCH;
                end
            end

            PORCH: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    state_d = XFER;
                end
            end

            XFER: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    // The last bit has been sampled but not shifted; fold it in here.
                    if (bit_cnt_q == SPI_CNT_FULL) begin
                        shft_d    = shift_in;
                        rx_data_d = shift_in;
                        rdy_d     = 1'b1;
                    end
                end else begin
                    if (sclk_rise && (bit_cnt_q != SPI_CNT_FULL)) begin
                        bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
                    end
                    if (sclk_fall && (bit_cnt_q < SPI_CNT_FULL)) begin
                        shft_d = shift_in;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shft_q      <= '0;
            bit_cnt_q   <= '0;
            mosi_smpl_q <= 1'b0;
            rx_data_q   <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shft_q      <= shft_d;
            bit_cnt_q   <= bit_cnt_d;
            mosi_smpl_q <= mosi_smpl_d;
            rx_data_q   <= rx_data_d;
            rdy_q       <= rdy_d;
        end
    end

    // The raw pin gates the driver so MISO releases the bus without synchronizer delay.
    assign MISO    = SS_n ? 1'bz : shft_q[SPI_WIDTH-1];
    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;

endmodule : spi_serf

// File: tb/tb_spi_serf.sv
// Bench for spi_serf: a monarch model drives two serfs (SYNC_STAGES 2 and 3)
// in parallel and compares both against a word-level reference model.
module tb_spi_serf;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, ss_n, sclk, mosi, tx_ld, clr_a, clr_b;
    logic [15:0] tx_data;
    wire         miso_a, miso_b;
    logic [15:0] rx_a, rx_b;
    logic        rdy_a, rdy_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_rx;
    logic        exp_rdy;
    logic [15:0] got_a, got_b;

    always #5 clk = ~clk;

    // Opposite pulls expose a serf that drives MISO while deselected, whatever bit it drives.
    pullup   (miso_a);
    pulldown (miso_b);

    spi_serf #(.SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi),
        .MISO(miso_a), .tx_data(tx_data), .tx_ld(tx_ld),
        .rx_data(rx_a), .rdy(rdy_a), .clr_rdy(clr_a)
    );

    spi_serf #(.SYNC_STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi),
        .MISO(miso_b), .tx_data(tx_data), .tx_ld(tx_ld),
        .rx_data(rx_b), .rdy(rdy_b), .clr_rdy(clr_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " rx_a"}, 32'(rx_a), 32'(exp_rx));
        check({tag, " rx_b"}, 32'(rx_b), 32'(exp_rx));
        check({tag, " rdy_a"}, 32'(rdy_a), 32'(exp_rdy));
        check({tag, " rdy_b"}, 32'(rdy_b), 32'(exp_rdy));
        check({tag, " state_a"}, 32'(dut_a.state_q), 32'(IDLE));
        check({tag, " state_b"}, 32'(dut_b.state_q), 32'(IDLE));
    endtask

    task automatic check_released(input string tag);
        check({tag, " miso_z_a"}, 32'(miso_a), 32'd1);
        check({tag, " miso_z_b"}, 32'(miso_b), 32'd0);
    endtask

    task automatic load_tx(input logic [15:0] v);
        @(negedge clk);
        tx_data = v;
        tx_ld   = 1'b1;
        @(negedge clk);
        tx_ld   = 1'b0;
    endtask

    task automatic clear_rdy(input string tag);
        @(negedge clk);
        clr_a = 1'b1;
        clr_b = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        clr_b = 1'b0;
        exp_rdy = 1'b0;
        check({tag, " clr rdy_a"}, 32'(rdy_a), 32'd0);
        check({tag, " clr rdy_b"}, 32'(rdy_b), 32'd0);
    endtask

    // Monarch: porch fall, then n_bits fall/rise pairs, MOSI driven on each fall
    // and MISO sampled just before each rise. SS_n stays low if release_ss is 0.
    task automatic xfer(input string tag, input logic [15:0] word, input int half,
                        input int n_bits, input bit release_ss, input bit collide);
        bit prev_rdy;
        int lat_a, lat_b;
        prev_rdy = exp_rdy;
        @(negedge clk);
        check_released(tag);
        ss_n  = 1'b0;
        got_a = '0;
        got_b = '0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < n_bits; i++) begin
            sclk = 1'b0;
            mosi = word[15-i];
            repeat (half) @(negedge clk);
            got_a = {got_a[14:0], miso_a};
            got_b = {got_b[14:0], miso_b};
            sclk = 1'b1;
            repeat (half) @(negedge clk);
        end
        if (release_ss) begin
            ss_n = 1'b1;
            if (n_bits == 16) begin
                if (collide) begin
                    repeat (2) @(posedge clk);
                    @(negedge clk);
                    clr_a = 1'b1;
                    @(negedge clk);
                    clr_a = 1'b0;
                    clr_b = 1'b1;
                    @(negedge clk);
                    clr_b = 1'b0;
                end else if (!prev_rdy) begin
                    lat_a = 0;
                    lat_b = 0;
                    for (int c = 1; c <= 6; c++) begin
                        @(negedge clk);
                        if (rdy_a && lat_a == 0) lat_a = c;
                        if (rdy_b && lat_b == 0) lat_b = c;
                    end
                    check({tag, " rdy_lat_a<=4"}, 32'(lat_a >= 1 && lat_a <= 4), 32'd1);
                    check({tag, " rdy_lat_b<=5"}, 32'(lat_b >= 1 && lat_b <= 5), 32'd1);
                end
                exp_rx  = word;
                exp_rdy = 1'b1;
                check({tag, " miso_word_a"}, 32'(got_a), 32'(tx_data));
                check({tag, " miso_word_b"}, 32'(got_b), 32'(tx_data));
            end
            repeat (6) @(negedge clk);
            check_outputs(tag);
            check_released(tag);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          half;
        int          pick;

        rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b1; mosi = 1'b0;
        tx_ld = 1'b0; clr_a = 1'b0; clr_b = 1'b0; tx_data = '0;
        exp_rx = '0; exp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        check_released("reset");

        // Basic transfer, SCLK period 16 clk.
        load_tx(16'hA5C3);
        xfer("s1", 16'h8F00, 8, 16, 1, 0);

        // Back-to-back without clearing rdy.
        load_tx(16'h3C3C);
        xfer("s2a", 16'h1234, 8, 16, 1, 0);
        load_tx(16'hC001);
        xfer("s2b", 16'hFFFF, 8, 16, 1, 0);

        // Completion and clr_rdy in the same clock: set wins.
        clear_rdy("s3");
        load_tx(16'h0F0F);
        xfer("s3", 16'hBEEF, 8, 16, 1, 1);
        clear_rdy("s3 lone");

        // Abort after 9 rises keeps the previous word and rdy.
        load_tx(16'h7E57);
        xfer("s4 pre", 16'h1234, 8, 16, 1, 0);
        load_tx(16'h4321);
        xfer("s4 abort", 16'hDEAD, 8, 9, 1, 0);
        check("s4 rx kept a", 32'(rx_a), 32'h1234);
        load_tx(16'h9999);
        xfer("s4 post", 16'h00FF, 8, 16, 1, 0);

        // Asynchronous reset after 5 bits of a transfer.
        load_tx(16'h1111);
        xfer("s5 cut", 16'hCAFE, 8, 5, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        exp_rx  = '0;
        exp_rdy = 1'b0;
        check_outputs("s5 in reset");
        ss_n = 1'b1;
        sclk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_released("s5 after");
        load_tx(16'h6C6C);
        xfer("s5 next", 16'h5A5A, 8, 16, 1, 0);

        // Fastest legal SCLK: period 8 clk.
        clear_rdy("s6");
        load_tx(16'hA5C3);
        xfer("s6", 16'h8F00, 4, 16, 1, 0);

        // Randomized traffic: full words, aborts and clears at varied SCLK rates.
        for (int k = 0; k < 20; k++) begin
            w    = 16'($urandom);
            half = $urandom_range(4, 8);
            pick = $urandom_range(0, 9);
            load_tx(16'($urandom));
            if (pick <= 2) clear_rdy("rnd");
            if (pick <= 1) xfer("rnd abort", w, half, $urandom_range(0, 15), 1, 0);
            else           xfer("rnd full", w, half, 16, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_serf
